// File: rtl/segment_scan_controller_pkg.sv
// Shared constants, blink phase type and digit-index helpers for the segment scan controller.
package seg_scan_pkg;

    localparam int MAX_DIGITS = 32;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_e;

    function automatic logic [MAX_DIGITS-1:0] an_off_mask(input int unsigned digits);
        logic [MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    // Searches cur+1, cur+2, ... with wrap and ends on cur itself, so a lone enabled digit maps to itself.
    function automatic int unsigned next_enabled(input logic [MAX_DIGITS-1:0] en,
                                                 input int unsigned cur,
                                                 input int unsigned digits);
        int unsigned result;
        int unsigned j;
        logic found;
        result = cur;
        found  = 1'b0;
        for (int unsigned k = 1; k <= MAX_DIGITS; k++) begin
            if (k <= digits && !found) begin
                j = cur + k;
                if (j >= digits) j = j - digits;
                if (en[j]) begin
                    result = j;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/segment_scan_controller_if.sv
// Core-side bus of the segment scan controller: pattern data, load strobe, enables and status.
interface segment_scan_controller_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS*8-1:0] seg_data;
    logic                load;
    logic [DIGITS-1:0]   digit_en;
    logic [DIGITS-1:0]   blink_mask;
    logic                busy;
    logic                frame_done;

    modport master (
        output seg_data, load, digit_en, blink_mask,
        input  busy, frame_done
    );

    modport slave (
        input  seg_data, load, digit_en, blink_mask,
        output busy, frame_done
    );
endinterface

// File: rtl/segment_scan_controller_prescaler.sv
// Digit-slot timer: counts 0..CLK_DIV-1, flags the last cycle of a slot and the leading blank window.
module scan_prescaler #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic in_blank
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick     = (count == CW'(CLK_DIV - 1));
    assign in_blank = (count < CW'(BLANK_CYC));

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexed seven-segment driver with double-buffered patterns and per-slot blanking.
// Optional blinking is compiled in with `define SEG_SCAN_BLINK_EN.
module segment_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    segment_scan_controller_if.slave  bus,
    output logic [DIGITS-1:0]         an,
    output logic [7:0]                seg
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [MAX_DIGITS-1:0] AN_OFF_WIDE = an_off_mask(DIGITS);
    localparam logic [DIGITS-1:0]     AN_OFF      = AN_OFF_WIDE[DIGITS-1:0];

    logic                  tick;
    logic                  in_blank;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         nxt_idx;
    logic [MAX_DIGITS-1:0] en_wide;
    logic                  any_en;
    logic                  boundary;
    logic                  lit;
    logic                  blink_dark;
    logic [DIGITS*8-1:0]   shadow;
    logic [DIGITS*8-1:0]   staging;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [DIGITS-1:0]     an_d;
    logic [7:0]            seg_d;

    scan_prescaler #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .in_blank (in_blank)
    );

    // A frame ends when the scan index fails to advance upward: wrap-around or a single enabled digit.
    always_comb begin
        en_wide              = '0;
        en_wide[DIGITS-1:0]  = bus.digit_en;
        any_en               = |bus.digit_en;
        nxt_idx              = IW'(next_enabled(en_wide, 32'(idx), DIGITS));
        boundary             = tick && any_en && (nxt_idx <= idx);
        lit                  = bus.digit_en[idx] && !in_blank && !blink_dark;
        an_d                 = AN_OFF;
        seg_d                = SEG_OFF;
        if (lit) begin
            an_d  = AN_OFF & ~(DIGITS'(1) << idx);
            seg_d = shadow[{idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            frame_done_q <= 1'b0;
            an           <= AN_OFF;
            seg          <= SEG_OFF;
        end else begin
            if (tick && any_en) idx <= nxt_idx;
            frame_done_q <= boundary;
            an           <= an_d;
            seg          <= seg_d;
        end
    end

    // A load landing on the boundary bypasses staging so it is never held back a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '1;
            staging <= '1;
            busy_q  <= 1'b0;
        end else begin
            if (bus.load) staging <= bus.seg_data;
            if (boundary && bus.load) begin
                shadow <= bus.seg_data;
                busy_q <= 1'b0;
            end else if (boundary && busy_q) begin
                shadow <= staging;
                busy_q <= 1'b0;
            end else if (bus.load) begin
                busy_q <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    blink_phase_e  phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= BLINK_ON;
        end else if (boundary) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Blinked digits keep their slot so the scan rate and brightness of the others do not change.
    assign blink_dark = (phase == BLINK_OFF) && bus.blink_mask[idx];
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;
    assign unused_blink_mask = ^bus.blink_mask;
    assign blink_dark        = 1'b0;
`endif

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed, table-driven bench for segment_scan_controller (DIGITS=8, CLK_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2).
module tb_segment_scan_controller;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        logic       exp_fd;
    } vec_t;

`ifdef SEG_SCAN_BLINK_EN
    localparam int NFRAMES = 6;
    localparam bit BLINK   = 1'b1;
`else
    localparam int NFRAMES = 1;
    localparam bit BLINK   = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] an;
    logic [7:0] seg;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [14];

    segment_scan_controller_if #(.DIGITS(8)) bus ();

    segment_scan_controller #(
        .DIGITS       (8),
        .CLK_DIV      (4),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One digit slot as seen on the registered outputs: one blank sample, then three lit samples.
    task automatic checkSlot(input string name, input logic [7:0] exp_an, input logic [7:0] exp_seg,
                             input logic exp_fd);
        stepCycle();
        checkOutput({name, " blank an"}, an, 8'hFF);
        checkOutput({name, " blank seg"}, seg, 8'hFF);
        checkOutput({name, " blank frame_done"}, bus.frame_done, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            stepCycle();
            checkOutput({name, " an"}, an, exp_an);
            checkOutput({name, " seg"}, seg, exp_seg);
            checkOutput({name, " frame_done"}, bus.frame_done, (k == 3) ? exp_fd : 1'b0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.digit_en = v.en;
        checkSlot("table", v.exp_an, v.exp_seg, v.exp_fd);
    endtask

    task automatic checkFrame(input string name, input logic [63:0] data);
        logic [7:0] exp_an;
        for (int s = 0; s < 8; s++) begin
            exp_an    = 8'hFF;
            exp_an[s] = 1'b0;
            checkSlot(name, exp_an, data[8*s +: 8], (s == 7));
        end
    endtask

    task automatic pulseLoad(input logic [63:0] data);
        bus.seg_data = data;
        bus.load     = 1'b1;
        stepCycle();
        bus.load     = 1'b0;
    endtask

    task automatic waitFrameDone(input int max_cycles, input bit expect_busy);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max_cycles) begin
            stepCycle();
            n++;
            if (bus.frame_done) seen = 1'b1;
            else if (expect_busy) checkOutput("busy held until boundary", bus.busy, 1'b1);
        end
        checkOutput("frame_done within budget", seen, 1'b1);
    endtask

    initial begin
        logic [7:0] exp_an;
        int         n;

        vecs[0]  = '{8'hFF, 8'hFE, 8'h77, 1'b0};
        vecs[1]  = '{8'hFF, 8'hFD, 8'h66, 1'b0};
        vecs[2]  = '{8'hFF, 8'hFB, 8'h55, 1'b0};
        vecs[3]  = '{8'hFF, 8'hF7, 8'h44, 1'b0};
        vecs[4]  = '{8'hFF, 8'hEF, 8'h33, 1'b0};
        vecs[5]  = '{8'hFF, 8'hDF, 8'h22, 1'b0};
        vecs[6]  = '{8'hFF, 8'hBF, 8'h11, 1'b0};
        vecs[7]  = '{8'hFF, 8'h7F, 8'h00, 1'b1};
        vecs[8]  = '{8'h25, 8'hFE, 8'h77, 1'b0};
        vecs[9]  = '{8'h25, 8'hFB, 8'h55, 1'b0};
        vecs[10] = '{8'h25, 8'hDF, 8'h22, 1'b1};
        vecs[11] = '{8'h25, 8'hFE, 8'h77, 1'b0};
        vecs[12] = '{8'h25, 8'hFB, 8'h55, 1'b0};
        vecs[13] = '{8'h25, 8'hDF, 8'h22, 1'b1};

        rst_n          = 1'b1;
        bus.seg_data   = '0;
        bus.load       = 1'b0;
        bus.digit_en   = 8'hFF;
        bus.blink_mask = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset an", an, 8'hFF);
        checkOutput("reset seg", seg, 8'hFF);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset frame_done", bus.frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] load pattern and scan all digits, then digits 0,2,5");
        stepCycle();
        stepCycle();
        pulseLoad(64'h0011223344556677);
        checkOutput("busy after load", bus.busy, 1'b1);
        waitFrameDone(100, 1'b1);
        checkOutput("busy cleared at boundary", bus.busy, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        $display("[TB] two loads before one boundary, latest wins");
        bus.digit_en = 8'hFF;
        stepCycle();
        stepCycle();
        pulseLoad(64'hA0A1A2A3A4A5A6A7);
        checkOutput("busy after load A", bus.busy, 1'b1);
        repeat (3) stepCycle();
        pulseLoad(64'hB0B1B2B3B4B5B6B7);
        checkOutput("busy after load B", bus.busy, 1'b1);
        waitFrameDone(100, 1'b1);
        checkOutput("busy cleared after B", bus.busy, 1'b0);
        checkFrame("frame B", 64'hB0B1B2B3B4B5B6B7);

        $display("[TB] load on the boundary tick");
        repeat (31) stepCycle();
        bus.seg_data = 64'hC0C1C2C3C4C5C6C7;
        bus.load     = 1'b1;
        stepCycle();
        bus.load     = 1'b0;
        checkOutput("coincident load frame_done", bus.frame_done, 1'b1);
        checkOutput("coincident load busy", bus.busy, 1'b0);
        checkFrame("frame C", 64'hC0C1C2C3C4C5C6C7);
        checkOutput("busy never set by coincident load", bus.busy, 1'b0);

        $display("[TB] all digits disabled, then reset mid-slot");
        bus.digit_en = 8'h00;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            checkOutput("disabled an", an, 8'hFF);
            checkOutput("disabled seg", seg, 8'hFF);
            checkOutput("disabled frame_done", bus.frame_done, 1'b0);
        end
        bus.digit_en = 8'hFF;
        n = 0;
        while (an == 8'hFF && n < 16) begin
            stepCycle();
            n++;
        end
        checkOutput("digit lit after re-enable", (an != 8'hFF), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset an", an, 8'hFF);
        checkOutput("async reset seg", seg, 8'hFF);
        checkOutput("async reset busy", bus.busy, 1'b0);
        checkOutput("async reset frame_done", bus.frame_done, 1'b0);
        bus.blink_mask = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] scan restarts at digit 0 with reset patterns");
        for (int f = 0; f < NFRAMES; f++) begin
            for (int s = 0; s < 8; s++) begin
                exp_an = 8'hFF;
                if (!(BLINK && s == 0 && (f == 2 || f == 3))) exp_an[s] = 1'b0;
                checkSlot("restart/blink", exp_an, 8'hFF, (s == 7));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
